// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-wide, strobe-less data memory.
// SB/SH are done as read-modify-write; loads are lane-extracted and extended.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req_valid/req_ready  request handshake (one request in flight)
//   req_we/req_funct3    store flag and RV32I funct3
//   req_addr/req_wdata   byte address and right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata/resp_err  extended load data (held) and error flag
//   mem_addr             word-aligned memory address
//   mem_r_enable         read strobe, mem_rdata valid next cycle
//   mem_w_enable         full-word write strobe
//   mem_wdata/mem_rdata  memory write word / registered read word
//
// Build option: LSU_MISALIGN_CHECK_EN makes misaligned H/W an error;
// otherwise the offending low address bits are cleared.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_r_enable,
  output logic        mem_w_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;

  logic        is_h;
  logic        is_w;
  logic        bad_f3;
  logic        bad_st;
  logic        bad_rng;
  logic        bad_mis;
  logic        req_err;
  logic [31:0] adj_addr;

  assign is_h    = (req_funct3[1:0] == 2'b01);
  assign is_w    = (req_funct3[1:0] == 2'b10);
  assign bad_f3  = (req_funct3 == 3'b011) ||
                   (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111);
  assign bad_st  = req_we & req_funct3[2];
  assign bad_rng = (req_addr >= 32'(MEM_BYTES));

`ifdef LSU_MISALIGN_CHECK_EN
  assign bad_mis  = (is_h & req_addr[0]) |
                    (is_w & (|req_addr[1:0]));
  assign adj_addr = req_addr;
`else
  assign bad_mis  = 1'b0;
  // Misaligned halves/words silently round down to their natural boundary.
  always_comb begin
    adj_addr = req_addr;
    if (is_h) adj_addr[0] = 1'b0;
    if (is_w) adj_addr[1:0] = 2'b00;
  end
`endif

  assign req_err = bad_f3 | bad_st | bad_rng | bad_mis;

  logic [31:0] shifted;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic [31:0] merged;

  assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};
  assign ld_b    = shifted[7:0];
  assign ld_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_val = mem_rdata;
    unique case (1'b1)
      (f3_q == 3'b000): ld_val = {{24{ld_b[7]}}, ld_b};
      (f3_q == 3'b100): ld_val = {24'b0, ld_b};
      (f3_q == 3'b001): ld_val = {{16{ld_h[15]}}, ld_h};
      (f3_q == 3'b101): ld_val = {16'b0, ld_h};
      default:          ld_val = mem_rdata;
    endcase
  end

  // Read-modify-write: only the addressed lane is replaced.
  always_comb begin
    merged = mem_rdata;
    if (f3_q[0])
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'b0;
      wdata_q    <= 16'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
      mem_wdata  <= 32'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= adj_addr;
            wdata_q <= req_wdata[15:0];
            if (req_err) begin
              resp_err <= 1'b1;
              state    <= DONE;
            end else begin
              resp_err <= 1'b0;
              if (req_we && is_w) begin
                mem_wdata <= req_wdata;
                state     <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD:  state <= CAP;
        CAP: begin
          if (we_q) begin
            mem_wdata <= merged;
            state     <= WR;
          end else begin
            resp_rdata <= ld_val;
            state      <= DONE;
          end
        end
        WR:   state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == DONE);
  assign mem_r_enable = (state == RD);
  assign mem_w_enable = (state == WR);
  assign mem_addr     = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a behavioural
// registered-read word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_r_enable (mem_r_enable),
    .mem_w_enable (mem_w_enable),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  bit          preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[100] <= 32'h04030201;
      mem[103] <= 32'hff0f0e0d;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_w_enable) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_r_enable) mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cur_rd  = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // is_ld selects whether ld_val is the expected resp_rdata; otherwise
  // resp_rdata must keep its previous value.
  task automatic op(input string tag, input bit we, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input int lat, input bit err, input bit is_ld,
                    input logic [31:0] ld_val, input int nr, input int nw,
                    input logic [31:0] maddr, input logic [31:0] wword);
    exp_t e;
    exp_t g;
    int   n;
    int   r;
    int   w;
    e.err = err;
    e.rd  = (is_ld && !err) ? ld_val : cur_rd;
    e.lat = lat;
    cur_rd = e.rd;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    r = 0;
    w = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (mem_r_enable && mem_w_enable)
        chk({tag, ".both_strobes"}, 32'd1, 32'd0);
      if (mem_r_enable) begin
        r++;
        chk({tag, ".raddr"}, mem_addr, maddr);
      end
      if (mem_w_enable) begin
        w++;
        chk({tag, ".waddr"}, mem_addr, maddr);
        chk({tag, ".wdata"}, mem_wdata, wword);
      end
      if (resp_valid || n > 20) break;
    end
    g = sb_q.pop_front();
    chk({tag, ".lat"}, 32'(n), 32'(g.lat));
    chk({tag, ".err"}, 32'(resp_err), 32'(g.err));
    chk({tag, ".rdata"}, resp_rdata, g.rd);
    chk({tag, ".nrd"}, 32'(r), 32'(nr));
    chk({tag, ".nwr"}, 32'(w), 32'(nw));
    chk({tag, ".rdy_busy"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int wcnt;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    preload    = 1'b1;
    repeat (2) @(posedge clk);
    preload = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.rvalid", 32'(resp_valid), 32'd0);
    chk("rst.err", 32'(resp_err), 32'd0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.ren", 32'(mem_r_enable), 32'd0);
    chk("rst.wen", 32'(mem_w_enable), 32'd0);
    chk("rst.addr", mem_addr, 32'h0);
    chk("rst.wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    op("lw400", 0, 3'b010, 400, 0, 3, 0, 1, 32'h04030201, 1, 0, 400, 0);
    op("lb415", 0, 3'b000, 415, 0, 3, 0, 1, 32'hffffffff, 1, 0, 412, 0);
    op("lbu415", 0, 3'b100, 415, 0, 3, 0, 1, 32'h000000ff, 1, 0, 412, 0);
    op("lh414", 0, 3'b001, 414, 0, 3, 0, 1, 32'hffffff0f, 1, 0, 412, 0);
    op("lhu414", 0, 3'b101, 414, 0, 3, 0, 1, 32'h0000ff0f, 1, 0, 412, 0);
    op("lb412", 0, 3'b000, 412, 0, 3, 0, 1, 32'h0000000d, 1, 0, 412, 0);
    op("sb401", 1, 3'b000, 401, 32'h123456aa, 4, 0, 0, 0, 1, 1, 400,
       32'h0403aa01);
    op("lw400b", 0, 3'b010, 400, 0, 3, 0, 1, 32'h0403aa01, 1, 0, 400, 0);
    op("sw400", 1, 3'b010, 400, 32'h04030201, 2, 0, 0, 0, 0, 1, 400,
       32'h04030201);
    op("sh402", 1, 3'b001, 402, 32'h00001234, 4, 0, 0, 0, 1, 1, 400,
       32'h12340201);
    op("lw400c", 0, 3'b010, 400, 0, 3, 0, 1, 32'h12340201, 1, 0, 400, 0);
    op("sw404", 1, 3'b010, 404, 32'hdeadbeef, 2, 0, 0, 0, 0, 1, 404,
       32'hdeadbeef);
    op("lw404", 0, 3'b010, 404, 0, 3, 0, 1, 32'hdeadbeef, 1, 0, 404, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    op("lw402", 0, 3'b010, 402, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    op("lh413", 0, 3'b001, 413, 0, 1, 1, 1, 0, 0, 0, 0, 0);
`else
    op("lw402", 0, 3'b010, 402, 0, 3, 0, 1, 32'h12340201, 1, 0, 400, 0);
    op("lh413", 0, 3'b001, 413, 0, 3, 0, 1, 32'h00000e0d, 1, 0, 412, 0);
`endif
    op("f3_011", 0, 3'b011, 400, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    op("lw1024", 0, 3'b010, 1024, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    op("sbu_st", 1, 3'b100, 400, 32'h55, 1, 1, 0, 0, 0, 0, 0, 0);
    op("lw1020", 0, 3'b010, 1020, 0, 3, 0, 1, 32'h0, 1, 0, 1020, 0);

    // Abort an SB in its CAP cycle.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 401;
    req_wdata  = 32'h99;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort.rd_phase", 32'(mem_r_enable), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.ren", 32'(mem_r_enable), 32'd0);
    chk("abort.wen", 32'(mem_w_enable), 32'd0);
    chk("abort.ready", 32'(req_ready), 32'd1);
    chk("abort.rvalid", 32'(resp_valid), 32'd0);
    chk("abort.rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cur_rd = 32'h0;
    wcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_w_enable) wcnt++;
    end
    chk("abort.no_wr", 32'(wcnt), 32'd0);
    chk("abort.mem400", mem[100], 32'h12340201);
    op("lw400d", 0, 3'b010, 400, 0, 3, 0, 1, 32'h12340201, 1, 0, 400, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
